// File: rtl/dbg_wb_dr.sv
// dbg_wb_dr: JTAG debug data register that shifts in a 65-bit command and runs one Wishbone access
//   tck_pad_i, trst_pad_i       JTAG clock, async active-high reset for both domains
//   tdi_i, debug_tdo_o          serial in from / out to the TAP
//   debug_select_i              DEBUG instruction selected; gates all TCK-side actions
//   capture_dr_i, shift_dr_i, update_dr_i  TAP state flags
//   wb_clk_i                    Wishbone clock, asynchronous to tck_pad_i
//   wb_adr_o, wb_dat_o, wb_dat_i, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i  Wishbone master
module dbg_wb_dr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        tck_pad_i,
    input  logic        trst_pad_i,
    input  logic        wb_clk_i,
    input  logic        tdi_i,
    input  logic        debug_select_i,
    input  logic        capture_dr_i,
    input  logic        shift_dr_i,
    input  logic        update_dr_i,
    output logic        debug_tdo_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    typedef enum logic [1:0] {S_IDLE, S_CYCLE, S_DONE} state_t;

    logic [64:0] sr;
    logic        busy, err, ovr, req_tgl, cmd_we, ack_edge;
    logic [31:0] rdata, cmd_adr, cmd_dat;
    logic [2:0]  ack_sync;

    logic [1:0]  rst_sync;
    logic        wb_rst, req_edge, in_cyc, timeout, term, err_wb, ack_tgl;
    logic [2:0]  req_sync;
    logic [7:0]  cnt;
    logic [31:0] rdata_wb;
    state_t      state, state_nxt;

    assign ack_edge = ack_sync[2] ^ ack_sync[1];

    // cmd_* are only rewritten while busy=0, so the wb domain may sample them unsynchronized.
    always_ff @(posedge tck_pad_i or posedge trst_pad_i) begin
        if (trst_pad_i) begin
            sr       <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            ovr      <= 1'b0;
            rdata    <= '0;
            req_tgl  <= 1'b0;
            cmd_we   <= 1'b0;
            cmd_adr  <= '0;
            cmd_dat  <= '0;
            ack_sync <= '0;
        end else if (debug_select_i) begin
            ack_sync <= {ack_sync[1:0], ack_tgl};
            if (capture_dr_i) begin
                sr  <= {30'b0, rdata, ovr, err, busy};
                ovr <= 1'b0;
            end else if (shift_dr_i) begin
                sr <= {tdi_i, sr[64:1]};
            end else if (update_dr_i) begin
                if (busy) begin
                    ovr <= 1'b1;
                end else begin
                    cmd_we  <= sr[0];
                    cmd_adr <= sr[32:1];
                    cmd_dat <= sr[64:33];
                    busy    <= 1'b1;
                    req_tgl <= ~req_tgl;
                end
            end
            // A capture on this same edge has already sampled the pre-completion status.
            if (ack_edge) begin
                busy  <= 1'b0;
                err   <= err_wb;
                rdata <= rdata_wb;
            end
        end
    end

    always_ff @(negedge tck_pad_i or posedge trst_pad_i) begin
        if (trst_pad_i) debug_tdo_o <= 1'b0;
        else            debug_tdo_o <= sr[0];
    end

    // Reset asserts into the wb domain at once but is released on wb_clk_i.
    always_ff @(posedge wb_clk_i or posedge trst_pad_i) begin
        if (trst_pad_i) rst_sync <= 2'b11;
        else            rst_sync <= {rst_sync[0], 1'b0};
    end

    assign wb_rst = rst_sync[1];

    always_ff @(posedge wb_clk_i or posedge wb_rst) begin
        if (wb_rst) begin
            state    <= S_IDLE;
            req_sync <= '0;
            cnt      <= '0;
            err_wb   <= 1'b0;
            rdata_wb <= '0;
            ack_tgl  <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_sync <= {req_sync[1:0], req_tgl};
            cnt      <= in_cyc ? cnt + 8'd1 : 8'd0;
            if (in_cyc && term) begin
                err_wb <= wb_err_i | timeout;
                if (wb_ack_i && !cmd_we) rdata_wb <= wb_dat_i;
            end
            if (state == S_DONE) ack_tgl <= ~ack_tgl;
        end
    end

    always_comb begin
        req_edge  = req_sync[2] ^ req_sync[1];
        in_cyc    = state == S_CYCLE;
        timeout   = cnt == 8'(TIMEOUT_CYCLES - 1);
        term      = wb_ack_i | wb_err_i | timeout;
        state_nxt = state == S_IDLE  ? (req_edge ? S_CYCLE : S_IDLE) :
                    state == S_CYCLE ? (term ? S_DONE : S_CYCLE) : S_IDLE;
        wb_cyc_o  = in_cyc;
        wb_stb_o  = in_cyc;
        wb_we_o   = in_cyc & cmd_we;
        wb_sel_o  = in_cyc ? 4'hF : 4'h0;
        wb_adr_o  = in_cyc ? cmd_adr : 32'h0;
        wb_dat_o  = in_cyc ? cmd_dat : 32'h0;
    end
endmodule

// File: tb/tb_dbg_wb_dr.sv
// tb_dbg_wb_dr: directed-vector and random bench for the debug Wishbone data register
module tb_dbg_wb_dr;
    localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_SIL = 3;

    logic        tck = 0, wb_clk = 0, trst = 1, tdi = 0, dsel = 0, cap = 0, sh = 0, upd = 0;
    logic        tdo, we, cyc, stb, ack = 0, berr = 0;
    logic [31:0] adr, dato, sdat = 0;
    logic [3:0]  bsel;
    int          tck_half = 10, wb_half = 7;

    always begin #(tck_half); tck = ~tck; end
    always begin #(wb_half); wb_clk = ~wb_clk; end

    dbg_wb_dr #(.TIMEOUT_CYCLES(8)) dut (
        .tck_pad_i(tck), .trst_pad_i(trst), .wb_clk_i(wb_clk), .tdi_i(tdi),
        .debug_select_i(dsel), .capture_dr_i(cap), .shift_dr_i(sh), .update_dr_i(upd),
        .debug_tdo_o(tdo), .wb_adr_o(adr), .wb_dat_o(dato), .wb_dat_i(sdat), .wb_we_o(we),
        .wb_sel_o(bsel), .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_ack_i(ack), .wb_err_i(berr)
    );

    int          mode = M_ACK, lat = 1;
    int          cyc_cnt = 0, fall_cnt = 0, len = 0, last_len = 0, scnt = 0;
    logic        prev_cyc = 0, m_we = 0;
    logic [31:0] m_adr = 0, m_dat = 0;
    logic [3:0]  m_sel = 0;

    // slave and bus monitor, both working on the falling wb edge
    always @(negedge wb_clk) begin
        if (cyc && !prev_cyc) begin
            cyc_cnt++; len = 0; m_adr = adr; m_dat = dato; m_we = we; m_sel = bsel;
        end
        if (!cyc && prev_cyc) begin fall_cnt++; last_len = len; end
        if (cyc) begin
            len++; scnt++;
            ack  = (mode == M_ACK || mode == M_BOTH) && scnt == lat;
            berr = (mode == M_ERR || mode == M_BOTH) && scnt == lat;
        end else begin
            scnt = 0; ack = 0; berr = 0;
        end
        prev_cyc = cyc;
    end

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [64:0] frame(input logic w, input logic [31:0] a, input logic [31:0] d);
        return {d, a, w};
    endfunction

    function automatic logic [64:0] status(input logic [31:0] rd, input logic o, input logic e, input logic b);
        return {30'b0, rd, o, e, b};
    endfunction

    task automatic tck_step;
        @(negedge tck); #1;
    endtask

    task automatic pulse_cap;
        cap = 1; tck_step(); cap = 0;
    endtask

    task automatic pulse_upd;
        upd = 1; tck_step(); upd = 0;
    endtask

    task automatic shift65(input logic [64:0] din, output logic [64:0] dout);
        for (int i = 0; i < 65; i++) begin
            dout[i] = tdo; tdi = din[i]; sh = 1; tck_step();
        end
        sh = 0;
    endtask

    task automatic scan(input logic [64:0] din, output logic [64:0] dout);
        pulse_cap(); shift65(din, dout);
    endtask

    task automatic wait_done(input int start);
        int n = 0;
        while (fall_cnt == start && n < 3000) begin tck_step(); n++; end
        chk("bus_cycle_end", n < 3000, 1);
        repeat (20) tck_step();
    endtask

    logic [31:0] cur_rd = 0;
    logic        cur_err = 0;

    task automatic run_txn(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int md, input int lt, input logic [31:0] sd,
                           input logic e_err, input logic [31:0] e_rd, input int e_len);
        logic [64:0] r;
        int start, c0;
        mode = md; lat = lt; sdat = sd; start = fall_cnt; c0 = cyc_cnt;
        scan(frame(w, a, d), r);
        pulse_upd();
        wait_done(start);
        scan('0, r);
        chk({nm, "_status"}, r, status(e_rd, 0, e_err, 0));
        chk({nm, "_ncyc"}, cyc_cnt, c0 + 1);
        chk({nm, "_we"}, m_we, w);
        chk({nm, "_adr"}, m_adr, a);
        chk({nm, "_dat"}, m_dat, d);
        chk({nm, "_sel"}, m_sel, 4'hF);
        chk({nm, "_len"}, last_len, e_len);
        cur_rd = e_rd; cur_err = e_err;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr, dat;
        int          mode, lat;
        logic [31:0] sdat;
        logic        e_err;
        logic [31:0] e_rd;
        int          e_len;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [64:0] r;
        int start, c0, n;
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, M_ACK,  2, 32'h0,        1'b0, 32'h0,        2};
        vecs[1] = '{1'b0, 32'h20, 32'h0,        M_ACK,  1, 32'h12345678, 1'b0, 32'h12345678, 1};
        vecs[2] = '{1'b0, 32'h24, 32'h0,        M_ERR,  1, 32'hFFFF0000, 1'b1, 32'h12345678, 1};
        vecs[3] = '{1'b0, 32'h28, 32'h0,        M_SIL,  1, 32'hAAAA5555, 1'b1, 32'h12345678, 8};
        vecs[4] = '{1'b1, 32'h30, 32'h0BADF00D, M_BOTH, 3, 32'h11111111, 1'b1, 32'h12345678, 3};
        vecs[5] = '{1'b0, 32'h34, 32'h0,        M_ACK,  4, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 4};

        #55;
        chk("rst_tdo", tdo, 0);
        chk("rst_bus", {cyc, stb, we, bsel, adr, dato}, '0);
        trst = 0; dsel = 1;
        tck_step();
        scan('0, r);
        chk("rst_capture", r, '0);

        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].mode,
                    vecs[i].lat, vecs[i].sdat, vecs[i].e_err, vecs[i].e_rd, vecs[i].e_len);

        // select low: shift and update must not touch sr or start a cycle
        c0 = cyc_cnt;
        pulse_cap();
        dsel = 0;
        shift65(frame(1, 32'h99, 32'h55), r);
        pulse_upd();
        repeat (60) tck_step();
        chk("gate_no_cycle", cyc_cnt, c0);
        dsel = 1;
        shift65('0, r);
        chk("gate_sr_kept", r, status(cur_rd, 0, cur_err, 0));

        // overrun: second update while the first access is still outstanding
        mode = M_SIL; start = fall_cnt; c0 = cyc_cnt;
        scan(frame(0, 32'h40, 32'h0), r);
        pulse_upd();
        pulse_upd();
        pulse_cap();
        shift65('0, r);
        chk("ovr_status", r, status(cur_rd, 1, cur_err, 1));
        wait_done(start);
        scan('0, r);
        chk("ovr_cleared", r, status(cur_rd, 0, 1, 0));
        chk("ovr_one_cycle", cyc_cnt, c0 + 1);
        chk("ovr_timeout_len", last_len, 8);
        cur_err = 1;

        // reset in the middle of a bus cycle
        mode = M_SIL;
        scan(frame(0, 32'h50, 32'h0), r);
        pulse_upd();
        n = 0;
        while (!cyc && n < 2000) begin #1; n++; end
        chk("rst_mid_cyc_seen", cyc, 1);
        #2; trst = 1; #1;
        chk("rst_mid_drop", {cyc, stb}, 2'b00);
        #100; trst = 0;
        tck_step();
        c0 = cyc_cnt;
        repeat (40) tck_step();
        chk("rst_mid_no_cycle", cyc_cnt, c0);
        scan('0, r);
        chk("rst_mid_capture", r, '0);
        cur_rd = 0; cur_err = 0;

        // random transactions at both clock ratios
        for (int k = 0; k < 2; k++) begin
            tck_half = k == 0 ? 35 : 5;
            wb_half  = k == 0 ? 5 : 35;
            tck_step();
            for (int t = 0; t < 50; t++) begin
                logic        w;
                logic [31:0] a, d, s, erd;
                int          md, lt;
                w = 1'($urandom_range(0, 1)); a = $urandom; d = $urandom; s = $urandom;
                md = $urandom_range(0, 3) == 0 ? M_ERR : M_ACK;
                lt = $urandom_range(1, 3);
                erd = (md == M_ACK && !w) ? s : cur_rd;
                run_txn($sformatf("rnd%0d_%0d", k, t), w, a, d, md, lt, s, md == M_ERR, erd, lt);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
